dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Arbitrates the single-port data memory between the pipeline's MEM stage (CPU port) and an external loader/debug port (EXT port). The CPU has fixed priority. A starvation counter forces one EXT grant after STARVE_LIMIT consecutive denied EXT cycles. The block sits between the MEM stage and dmem, drives the dmem address/data/enable pins, and returns registered read data to each requester.

Parameters:
ADDR_WIDTH, 10, dmem word-address width
DATA_WIDTH, 32, data width
STARVE_LIMIT, 4, consecutive denied EXT cycles before a forced EXT grant (1..2^CNT_WIDTH-1)
CNT_WIDTH, 4, starvation counter width

Ports:
clk  in  1  system clock
reset_b  in  1  reset, synchronous, active-low
cpu_req  in  1  CPU access request (MEM stage mem_read|mem_write)
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_WIDTH  CPU word address
cpu_wdata  in  DATA_WIDTH  CPU store data
cpu_gnt  out  1  CPU access performed this cycle; cpu_req&~cpu_gnt = stall
cpu_rdata  out  DATA_WIDTH  registered CPU read data
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
ext_req  in  1  EXT request; must be held with stable we/addr/wdata until ext_gnt
ext_we  in  1  1=write, 0=read
ext_addr  in  ADDR_WIDTH  EXT word address
ext_wdata  in  DATA_WIDTH  EXT write data
ext_gnt  out  1  EXT access performed this cycle
ext_rdata  out  DATA_WIDTH  registered EXT read data
ext_rvalid  out  1  one-cycle pulse, ext_rdata valid
mem_addr  out  ADDR_WIDTH  to dmem addr
mem_din  out  DATA_WIDTH  to dmem din
mem_read  out  1  to dmem mem_read
mem_write  out  1  to dmem mem_write
mem_dout  in  DATA_WIDTH  from dmem dout (combinational read)

Behaviour:
- FSM states: CPU_PRI, EXT_FORCE. Starvation counter starve_cnt[CNT_WIDTH-1:0].
- Grants are combinational from current state and requests. At most one grant per cycle. Never grant without a request.
- CPU_PRI: cpu_req -> cpu_gnt. Otherwise ext_req -> ext_gnt.
- EXT_FORCE: ext_req -> ext_gnt and cpu_gnt=0. If ext_req=0, cpu_req -> cpu_gnt.
- starve_cnt: increments on each CPU_PRI cycle with ext_req&cpu_req. Clears on ext_gnt, on ext_req=0, and on leaving EXT_FORCE.
- Transition CPU_PRI->EXT_FORCE at the clock edge where the increment brings starve_cnt to STARVE_LIMIT.
- EXT_FORCE lasts exactly one cycle, then returns to CPU_PRI unconditionally.
- Steady contention with STARVE_LIMIT=N gives a repeating pattern of N CPU grants followed by 1 EXT grant.
- Memory mux: granted port drives mem_addr/mem_din. mem_write = gnt&we; mem_read = gnt&~we.
- With no grant: mem_read=mem_write=0 and mem_addr/mem_din=0.
- Writes complete at the grant-cycle clock edge; no response pulse for writes.
- Reads: at the grant-cycle edge, mem_dout is captured into the granted port's rdata and its rvalid goes high the next cycle for one cycle. Latency is 1.
- rdata holds its value until the next read for that port.
- Back-to-back reads to the same port give an rvalid pulse every cycle.
- Reset (reset_b=0 at posedge): state=CPU_PRI, starve_cnt=0, cpu/ext_rvalid=0, cpu/ext_rdata=0.
- While reset_b=0, cpu_gnt=ext_gnt=mem_read=mem_write=0, so no writes occur.
- Reset mid-contention or in EXT_FORCE discards the pending forced grant. A pending rvalid is suppressed.
- Simultaneous CPU and EXT access to the same address: no special handling; the grant order determines the result.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined: adds outputs conflict_cnt[31:0] (cycles with cpu_req&ext_req) and cpu_stall_cnt[31:0] (cycles with cpu_req&~cpu_gnt).
- Both counters are saturating, cleared on reset, and updated every cycle.
- Undefined: these ports and counters do not exist; arbitration is identical.

Test Plan:
1. CPU write 0xDEADBEEF @0x010, then CPU read @0x010, EXT idle -> cpu_gnt=1 both cycles; cpu_rvalid pulses the cycle after the read with cpu_rdata=0xDEADBEEF; ext_gnt stays 0.
2. EXT write 0x12345678 @0x3FF, then EXT read, CPU idle -> ext_gnt=1 immediately; ext_rvalid next cycle with 0x12345678; cpu_rvalid=0.
3. STARVE_LIMIT=4, cpu_req and ext_req (read) held high 10 cycles -> cpu_gnt in cycles 0-3, ext_gnt in cycle 4, cpu_gnt in cycles 5-8, ext_gnt in cycle 9; exactly one grant per cycle.
4. Contention for 4 cycles reaching EXT_FORCE, then ext_req dropped in that cycle -> cpu_gnt=1 in the EXT_FORCE cycle; the next cycle is CPU_PRI with starve_cnt=0.
5. reset_b=0 for 1 cycle during contention with starve_cnt=3 -> no grants or mem writes during reset; afterwards 4 more CPU grants precede the next EXT grant; both rvalid=0.
6. With DMEM_ARB_STATS_EN, scenario 3 -> conflict_cnt=10, cpu_stall_cnt=2 at the end; rebuilt without the macro, grant sequence unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: fixed CPU priority with a starvation-forced EXT grant.
// Optional DMEM_ARB_STATS_EN adds saturating conflict/stall counters.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  ext_gnt,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic                  ext_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_dout
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]           conflict_cnt,
    output logic [31:0]           cpu_stall_cnt
`endif
);

    // state     | meaning
    // CPU_PRI   | CPU wins every conflict; starvation counter runs
    // EXT_FORCE | single cycle where a waiting EXT request wins
    typedef enum logic {
        CPU_PRI   = 1'b0,
        EXT_FORCE = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   starve_cnt_q, starve_cnt_d;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic [DATA_WIDTH-1:0]  cpu_rdata_q, ext_rdata_q;
    logic                   cpu_rvalid_q, ext_rvalid_q;

    assign cnt_inc = starve_cnt_q + 1'b1;

    // Grants are gated by reset so nothing reaches dmem while held in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        if (reset_b) begin
            case (state_q)
                CPU_PRI: begin
                    cpu_gnt = cpu_req;
                    ext_gnt = ext_req & ~cpu_req;
                end
                EXT_FORCE: begin
                    ext_gnt = ext_req;
                    cpu_gnt = cpu_req & ~ext_req;
                end
                default: begin
                    cpu_gnt = 1'b0;
                    ext_gnt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_d      = CPU_PRI;
        starve_cnt_d = '0;
        case (state_q)
            CPU_PRI: begin
                if (cpu_req && ext_req) begin
                    starve_cnt_d = cnt_inc;
                    if (cnt_inc == LIMIT) begin
                        state_d = EXT_FORCE;
                    end
                end
            end
            EXT_FORCE: begin
                state_d      = CPU_PRI;
                starve_cnt_d = '0;
            end
            default: begin
                state_d      = CPU_PRI;
                starve_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q      <= CPU_PRI;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_din   = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_din   = cpu_wdata;
            mem_read  = ~cpu_we;
            mem_write = cpu_we;
        end else if (ext_gnt) begin
            mem_addr  = ext_addr;
            mem_din   = ext_wdata;
            mem_read  = ~ext_we;
            mem_write = ext_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            cpu_rdata_q  <= '0;
            ext_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            ext_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q <= cpu_gnt & ~cpu_we;
            ext_rvalid_q <= ext_gnt & ~ext_we;
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata_q <= mem_dout;
            end
            if (ext_gnt && !ext_we) begin
                ext_rdata_q <= mem_dout;
            end
        end
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign ext_rdata  = ext_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign ext_rvalid = ext_rvalid_q;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] conflict_cnt_q, cpu_stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            conflict_cnt_q  <= '0;
            cpu_stall_cnt_q <= '0;
        end else begin
            if (cpu_req && ext_req && (conflict_cnt_q != '1)) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
            if (cpu_req && !cpu_gnt && (cpu_stall_cnt_q != '1)) begin
                cpu_stall_cnt_q <= cpu_stall_cnt_q + 32'd1;
            end
        end
    end

    assign conflict_cnt  = conflict_cnt_q;
    assign cpu_stall_cnt = cpu_stall_cnt_q;
`endif

endmodule
